quad_sine_nco: RTL and testbench
================================

Name: quad_sine_nco

Overview:
Parametrised quadrature numerically controlled oscillator (NCO) for the SDR carrier-generation path. It accumulates a phase increment on each sample-clock enable and adds a programmable phase offset. It then produces registered two's-complement sine and cosine samples from a quarter-wave lookup table. It feeds the I/Q mixers and replaces the single-output full-table sine generator.

Parameters:
PHASE_W, 64, phase accumulator / increment / offset width in bits
LUT_AW, 8, full-wave table address bits (N = 2^LUT_AW points per cycle); must be >= 3
OUT_W, 12, sine/cosine output width, signed two's complement
AMP, 2^(OUT_W-1)-1, peak amplitude used to compute table contents

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
sample_clock_ce  in  1  sample-rate clock enable; the accumulator and all pipeline stages advance only when it is high
phase_inc  in  PHASE_W  phase increment per sample, modulo 2^PHASE_W (a two's-complement negative value gives a negative frequency)
phase_offset  in  PHASE_W  static phase offset added after the accumulator
sync_clr  in  1  synchronous accumulator clear, qualified by sample_clock_ce
sin_out  out  OUT_W  signed sine sample
cos_out  out  OUT_W  signed cosine sample
out_valid  out  1  high once the pipeline holds real samples

Behaviour:
- Reset (async, any time, including mid-run): accumulator P, all pipeline registers, sin_out, cos_out = 0; out_valid = 0; fill counter = 0.
- Accumulator, on a ce edge:
  - sync_clr=1: P <= 0.
  - otherwise: P <= P + phase_inc, wraps mod 2^PHASE_W with no saturation.
- Stage 1, on a ce edge: Ph <= (P + phase_offset) mod 2^PHASE_W, using P before this edge. ks <= Ph top LUT_AW bits. kc <= ks + N/4 mod N.
- Stage 2, on a ce edge: for each of ks and kc, quadrant q = k[LUT_AW-1:LUT_AW-2], j = k[LUT_AW-3:0].
  - Register a table address of j if q is 0 or 2, else ~j (bitwise inverse).
  - Register negate flag = q[1].
- Stage 3, on a ce edge: out <= negate ? -Q[addr] : Q[addr] for sin_out and cos_out.
- Quarter table: Q[j] = trunc_toward_zero(AMP * sin(2*pi*(j+0.5)/N)), for j = 0 .. N/4-1.
  - The half-step offset makes the mirror and negation exact, so full-wave entry k = -(entry k+N/2).
  - The table is a case ROM or initialised array, shared or duplicated per channel as timing requires.
- Latency: the P value present before ce edge n appears on the outputs after ce edge n+2 (three ce-qualified stages, including edge n).
- ce low: every register holds, outputs are stable, and no internal state changes.
- out_valid: a 2-bit fill counter increments on each ce edge until it reaches 3. out_valid = 1 from the third ce edge after reset and stays high until the next rst.
- sync_clr does not flush the pipeline and does not drop out_valid. The 0-phase sample appears 3 ce edges after the clearing edge.
- phase_inc and phase_offset changes take effect at the next ce edge. No glitch protection beyond registration.
- Output widths are exact: no clipping is needed, because |Q| <= AMP <= 2^(OUT_W-1)-1, so negation cannot overflow.

Test Plan:
1. Defaults, rst pulse, ce=1 every clk, phase_inc=2^56, offset=0 -> out_valid rises on the 3rd ce edge.
   - sin_out sequence: 0x019, 0x04B, 0x07D, ... reaches 0x7FE at k=63, then 0xFE7 at k=128.
   - cos_out first sample: 0x7FE.
2. As in 1 but phase_offset=2^62 -> sin_out sequence equals the cos_out sequence of run 1, sample for sample.
3. phase_inc=2^63, offset=0 -> sin_out alternates 0x019 and 0xFE7; cos_out alternates 0x7FE and 0x802.
4. ce asserted 1 clk in 4, phase_inc=2^56 -> outputs change only on cycles following ce edges and hold for 3 clks in between; the values match run 1.
5. Run 1 for 20 ce edges, then assert sync_clr with ce -> 3 ce edges later sin_out=0x019 and cos_out=0x7FE, and the sequence restarts; out_valid stays 1.
6. Assert rst asynchronously mid-run, between clk edges -> sin_out, cos_out, and out_valid go to 0 immediately. After release, behaviour is identical to run 1.

Source files
------------

// File: rtl/quad_sine_nco.sv
// Quadrature NCO: phase accumulator plus offset, quarter-wave sine ROM,
// registered signed sine/cosine outputs three sample-enables after the phase.
module quad_sine_nco #(
  parameter int PHASE_W = 64,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 12,
  parameter int AMP     = 2**(OUT_W-1) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_clock_ce,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               sync_clr,
  output logic [OUT_W-1:0]   sin_out,
  output logic [OUT_W-1:0]   cos_out,
  output logic               out_valid
);

  localparam int N   = 2**LUT_AW;
  localparam int QN  = N / 4;
  localparam int QAW = LUT_AW - 2;

  logic        [PHASE_W-1:0] r_acc;
  logic        [LUT_AW-1:0]  w_ks;
  logic        [LUT_AW-1:0]  w_kc;
  logic        [LUT_AW-1:0]  r_ks_p1;
  logic        [LUT_AW-1:0]  r_kc_p1;
  logic        [QAW-1:0]     r_sa_p2;
  logic        [QAW-1:0]     r_ca_p2;
  logic                      r_sn_p2;
  logic                      r_cn_p2;
  logic signed [OUT_W-1:0]   r_sin_p3;
  logic signed [OUT_W-1:0]   r_cos_p3;
  logic        [1:0]         r_fill;
  logic signed [OUT_W-1:0]   w_qtab [QN];

  // Negation is exact: table magnitudes never exceed 2^(OUT_W-1)-1.
  function automatic logic signed [OUT_W-1:0] apply_sign(
    input logic signed [OUT_W-1:0] mag,
    input logic                    neg
  );
    return neg ? -mag : mag;
  endfunction

  // Quarter-wave ROM sampled at half-step points so mirror/negate are exact.
  for (genvar g = 0; g < QN; g++) begin : g_qtab
    localparam real ANG = 2.0 * 3.14159265358979323846 * (real'(g) + 0.5) / real'(N);
    localparam int  QV  = $rtoi(real'(AMP) * $sin(ANG));
    assign w_qtab[g] = OUT_W'(QV);
  end

  // Top LUT_AW bits of the offset phase; cosine index leads by a quarter turn.
  assign w_ks = LUT_AW'((r_acc + phase_offset) >> (PHASE_W - LUT_AW));
  assign w_kc = w_ks + LUT_AW'(QN);

  // Phase accumulator, wrapping modulo 2^PHASE_W, clearable on a sample edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (sample_clock_ce) begin
      r_acc <= sync_clr ? '0 : r_acc + phase_inc;
    end
  end

  // Stage 1: capture sine and cosine full-wave table indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ks_p1 <= '0;
      r_kc_p1 <= '0;
    end else if (sample_clock_ce) begin
      r_ks_p1 <= w_ks;
      r_kc_p1 <= w_kc;
    end
  end

  // Stage 2: fold index into quarter-table address (mirror in odd quadrants) and sign flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa_p2 <= '0;
      r_ca_p2 <= '0;
      r_sn_p2 <= 1'b0;
      r_cn_p2 <= 1'b0;
    end else if (sample_clock_ce) begin
      r_sa_p2 <= r_ks_p1[QAW] ? ~r_ks_p1[QAW-1:0] : r_ks_p1[QAW-1:0];
      r_ca_p2 <= r_kc_p1[QAW] ? ~r_kc_p1[QAW-1:0] : r_kc_p1[QAW-1:0];
      r_sn_p2 <= r_ks_p1[LUT_AW-1];
      r_cn_p2 <= r_kc_p1[LUT_AW-1];
    end
  end

  // Stage 3: table lookup and conditional negation into the output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sin_p3 <= '0;
      r_cos_p3 <= '0;
    end else if (sample_clock_ce) begin
      r_sin_p3 <= apply_sign(w_qtab[r_sa_p2], r_sn_p2);
      r_cos_p3 <= apply_sign(w_qtab[r_ca_p2], r_cn_p2);
    end
  end

  // Fill counter: saturates at 3 once the pipeline holds real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill <= 2'd0;
    end else if (sample_clock_ce && (r_fill != 2'd3)) begin
      r_fill <= r_fill + 2'd1;
    end
  end

  assign sin_out   = r_sin_p3;
  assign cos_out   = r_cos_p3;
  assign out_valid = (r_fill == 2'd3);

endmodule

// File: tb/tb_quad_sine_nco.sv
// Directed bench for quad_sine_nco with default parameters (N=256, 12-bit out).
module tb_quad_sine_nco;

  logic        clk;
  logic        rst;
  logic        sample_clock_ce;
  logic [63:0] phase_inc;
  logic [63:0] phase_offset;
  logic        sync_clr;
  logic [11:0] sin_out;
  logic [11:0] cos_out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] INC_256 = 64'h0100_0000_0000_0000;
  localparam logic [63:0] QUARTER = 64'h4000_0000_0000_0000;
  localparam logic [63:0] HALF    = 64'h8000_0000_0000_0000;

  quad_sine_nco dut (
    .clk             (clk),
    .rst             (rst),
    .sample_clock_ce (sample_clock_ce),
    .phase_inc       (phase_inc),
    .phase_offset    (phase_offset),
    .sync_clr        (sync_clr),
    .sin_out         (sin_out),
    .cos_out         (cos_out),
    .out_valid       (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    sample_clock_ce = 1'b0;
    phase_inc       = INC_256;
    phase_offset    = '0;
    sync_clr        = 1'b0;
    #1;
    chk("rst_sin", 32'(sin_out), 32'h000);
    chk("rst_cos", 32'(cos_out), 32'h000);
    chk("rst_vld", 32'(out_valid), 32'h0);

    // Run 1: 256 points per cycle, no offset.
    sample_clock_ce = 1'b1;
    do_reset();
    tick(); chk("r1_vld_e1", 32'(out_valid), 32'h0);
    tick(); chk("r1_vld_e2", 32'(out_valid), 32'h0);
    tick(); chk("r1_vld_e3", 32'(out_valid), 32'h1);
    chk("r1_sin_k0", 32'(sin_out), 32'h019);
    chk("r1_cos_k0", 32'(cos_out), 32'h7FE);
    tick();
    chk("r1_sin_k1", 32'(sin_out), 32'h04B);
    chk("r1_cos_k1", 32'(cos_out), 32'h7FD);
    tick();
    chk("r1_sin_k2", 32'(sin_out), 32'h07D);
    chk("r1_cos_k2", 32'(cos_out), 32'h7FB);
    tick_n(61); chk("r1_sin_k63", 32'(sin_out), 32'h7FE);
    tick();     chk("r1_sin_k64", 32'(sin_out), 32'h7FE);
    tick_n(64); chk("r1_sin_k128", 32'(sin_out), 32'hFE7);
    tick_n(64); chk("r1_sin_k192", 32'(sin_out), 32'h802);

    // Run 2: quarter-turn offset turns sine into run-1 cosine.
    phase_offset = QUARTER;
    do_reset();
    tick_n(3);
    chk("r2_sin_k0", 32'(sin_out), 32'h7FE);
    chk("r2_cos_k0", 32'(cos_out), 32'hFE7);
    tick(); chk("r2_sin_k1", 32'(sin_out), 32'h7FD);
    tick(); chk("r2_sin_k2", 32'(sin_out), 32'h7FB);

    // Run 3: half-turn increment alternates.
    phase_offset = '0;
    phase_inc    = HALF;
    do_reset();
    tick_n(3);
    chk("r3_sin_a", 32'(sin_out), 32'h019);
    chk("r3_cos_a", 32'(cos_out), 32'h7FE);
    tick();
    chk("r3_sin_b", 32'(sin_out), 32'hFE7);
    chk("r3_cos_b", 32'(cos_out), 32'h802);
    tick();
    chk("r3_sin_c", 32'(sin_out), 32'h019);
    chk("r3_cos_c", 32'(cos_out), 32'h7FE);

    // Run 4: clock enable one clock in four.
    phase_inc       = INC_256;
    sample_clock_ce = 1'b0;
    do_reset();
    sample_clock_ce = 1'b1; tick(); sample_clock_ce = 1'b0; tick_n(3);
    sample_clock_ce = 1'b1; tick(); sample_clock_ce = 1'b0; tick_n(3);
    chk("r4_vld_2ce", 32'(out_valid), 32'h0);
    sample_clock_ce = 1'b1; tick(); sample_clock_ce = 1'b0;
    chk("r4_vld_3ce", 32'(out_valid), 32'h1);
    chk("r4_sin_k0", 32'(sin_out), 32'h019);
    tick_n(3);
    chk("r4_sin_hold", 32'(sin_out), 32'h019);
    chk("r4_cos_hold", 32'(cos_out), 32'h7FE);
    sample_clock_ce = 1'b1; tick(); sample_clock_ce = 1'b0;
    chk("r4_sin_k1", 32'(sin_out), 32'h04B);
    tick_n(3);
    chk("r4_sin_hold1", 32'(sin_out), 32'h04B);
    sample_clock_ce = 1'b1; tick(); sample_clock_ce = 1'b0;
    chk("r4_sin_k2", 32'(sin_out), 32'h07D);

    // Run 5: sync_clr after 20 sample edges restarts the sequence.
    sample_clock_ce = 1'b1;
    do_reset();
    tick_n(20);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    chk("r5_vld_clr", 32'(out_valid), 32'h1);
    tick_n(2);
    chk("r5_sin_pre", 32'(sin_out) == 32'h019 ? 32'h1 : 32'h0, 32'h0);
    tick();
    chk("r5_sin_k0", 32'(sin_out), 32'h019);
    chk("r5_cos_k0", 32'(cos_out), 32'h7FE);
    chk("r5_vld_k0", 32'(out_valid), 32'h1);
    tick();
    chk("r5_sin_k1", 32'(sin_out), 32'h04B);

    // Run 6: asynchronous reset mid-run, between edges.
    tick_n(10);
    #3;
    rst = 1'b1;
    #1;
    chk("r6_sin_async", 32'(sin_out), 32'h000);
    chk("r6_cos_async", 32'(cos_out), 32'h000);
    chk("r6_vld_async", 32'(out_valid), 32'h0);
    #1;
    rst = 1'b0;
    tick_n(2); chk("r6_vld_e2", 32'(out_valid), 32'h0);
    tick();
    chk("r6_vld_e3", 32'(out_valid), 32'h1);
    chk("r6_sin_k0", 32'(sin_out), 32'h019);
    chk("r6_cos_k0", 32'(cos_out), 32'h7FE);
    tick();
    chk("r6_sin_k1", 32'(sin_out), 32'h04B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
